stack_engine: RTL and testbench

STACK_ENGINE -- requirements
Module: stack_engine

---
 rtl/stack_pkg.sv | 19 +
 rtl/stack_engine_if.sv | 28 ++
 rtl/stack_mem.sv | 26 ++
 rtl/stack_engine.sv | 117 +++++++++++
 tb/tb_stack_engine.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared command encoding and width helpers for the stack engine.
package stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_engine_if.sv
// Command/result bundle between a stack engine and its client.
interface stack_engine_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5
);
    localparam int IW = stack_pkg::idx_width(DEPTH);
    localparam int CW = stack_pkg::cnt_width(DEPTH);

    logic [1:0]       command;
    logic [IW-1:0]    index;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             error;

    modport master (
        output command, index, data_in,
        input  data_out, out_valid, count, full, empty, error
    );

    modport slave (
        input  command, index, data_in,
        output data_out, out_valid, count, full, empty, error
    );
endinterface

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one combinational read port, no reset.
module stack_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-power-of-two depths leave unused address codes; read them as zero.
    assign rdata = ({1'b0, raddr} < (AW+1)'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/stack_engine.sv
// LIFO engine with push/pop/peek-by-depth, optional overwrite-oldest when full.
module stack_engine
    import stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int WRAP  = 0
) (
    input  logic           clk,
    input  logic           reset,
    stack_engine_if.slave  bus
);

    localparam int PW = idx_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam int XW = (PW > CW) ? PW : CW;

    logic [PW-1:0]    top_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] data_out_q;
    logic             out_valid_q;
    logic             error_q;

    cmd_e             cmd;
    logic             full;
    logic             empty;
    logic             get_ok;
    logic             push_ok;
    logic [PW-1:0]    ptr_up;
    logic [PW-1:0]    ptr_dn;
    logic [PW-1:0]    get_addr;
    logic [PW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic             we;

    assign cmd   = cmd_e'(bus.command);
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign ptr_up = (top_ptr == PW'(DEPTH - 1)) ? '0 : top_ptr + PW'(1);
    assign ptr_dn = (top_ptr == '0) ? PW'(DEPTH - 1) : top_ptr - PW'(1);

    // When the index reaches past slot 0 the true address is below DEPTH,
    // so PW-bit arithmetic cannot overflow the result.
    assign get_addr = (bus.index > top_ptr) ? top_ptr + PW'(DEPTH) - bus.index
                                            : top_ptr - bus.index;
    assign get_ok   = (XW'(bus.index) < XW'(count_q));
    assign raddr    = (cmd == CMD_GET) ? get_addr : top_ptr;

    assign push_ok = !full || (WRAP != 0);
    assign we      = !reset && (cmd == CMD_PUSH) && push_ok;

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (ptr_up),
        .wdata (bus.data_in),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            top_ptr     <= PW'(DEPTH - 1);
            count_q     <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
            unique case (cmd)
                CMD_PUSH: begin
                    if (!full) begin
                        top_ptr <= ptr_up;
                        count_q <= count_q + CW'(1);
                    end else if (WRAP != 0) begin
                        top_ptr <= ptr_up;
                    end else begin
                        error_q <= 1'b1;
                    end
                end
                CMD_POP: begin
                    if (!empty) begin
                        data_out_q  <= rdata;
                        out_valid_q <= 1'b1;
                        top_ptr     <= ptr_dn;
                        count_q     <= count_q - CW'(1);
                    end else begin
                        error_q <= 1'b1;
                    end
                end
                CMD_GET: begin
                    if (get_ok) begin
                        data_out_q  <= rdata;
                        out_valid_q <= 1'b1;
                    end else begin
                        error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.error     = error_q;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;

endmodule

// File: tb/tb_stack_engine.sv
// Checks three stack_engine configurations against a queue-based LIFO model.
module tb_stack_engine;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic [2:0] reset_v;

    always #5 clk = ~clk;

    stack_engine_if #(.WIDTH(4),  .DEPTH(5)) bus_a ();
    stack_engine_if #(.WIDTH(4),  .DEPTH(5)) bus_b ();
    stack_engine_if #(.WIDTH(16), .DEPTH(8)) bus_c ();

    stack_engine #(.WIDTH(4),  .DEPTH(5), .WRAP(0)) dut_a (.clk(clk), .reset(reset_v[0]), .bus(bus_a));
    stack_engine #(.WIDTH(4),  .DEPTH(5), .WRAP(1)) dut_b (.clk(clk), .reset(reset_v[1]), .bus(bus_b));
    stack_engine #(.WIDTH(16), .DEPTH(8), .WRAP(0)) dut_c (.clk(clk), .reset(reset_v[2]), .bus(bus_c));

    int checks = 0;
    int errors = 0;

    // Model: q[0] is the top of stack.
    int          m_depth;
    int          m_wrap;
    logic [15:0] m_mask;
    logic [15:0] q[$];
    logic [15:0] m_dout;
    logic        m_v;
    logic        m_e;

    logic [15:0] o_dout;
    logic        o_v, o_e, o_full, o_empty;
    int          o_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic use_dut(input int depth, input int wrap, input int width);
        m_depth = depth;
        m_wrap  = wrap;
        m_mask  = 16'((32'd1 << width) - 1);
    endtask

    task automatic model(input cmd_e cmd, input int idx, input logic [15:0] din, input bit rst);
        m_v = 1'b0;
        m_e = 1'b0;
        if (rst) begin
            q.delete();
            m_dout = '0;
        end else begin
            case (cmd)
                CMD_PUSH: begin
                    if (q.size() < m_depth) q.push_front(din & m_mask);
                    else if (m_wrap != 0) begin
                        void'(q.pop_back());
                        q.push_front(din & m_mask);
                    end else m_e = 1'b1;
                end
                CMD_POP: begin
                    if (q.size() > 0) begin
                        m_dout = q.pop_front();
                        m_v    = 1'b1;
                    end else m_e = 1'b1;
                end
                CMD_GET: begin
                    if (idx < q.size()) begin
                        m_dout = q[idx];
                        m_v    = 1'b1;
                    end else m_e = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input int sel, input cmd_e cmd, input int idx, input logic [15:0] din,
                         input bit rst, input string tag);
        @(negedge clk);
        reset_v = 3'b000;
        bus_a.command = CMD_NOP; bus_a.index = '0; bus_a.data_in = '0;
        bus_b.command = CMD_NOP; bus_b.index = '0; bus_b.data_in = '0;
        bus_c.command = CMD_NOP; bus_c.index = '0; bus_c.data_in = '0;
        reset_v[sel] = rst;
        case (sel)
            0: begin bus_a.command = cmd; bus_a.index = 3'(idx); bus_a.data_in = 4'(din); end
            1: begin bus_b.command = cmd; bus_b.index = 3'(idx); bus_b.data_in = 4'(din); end
            default: begin bus_c.command = cmd; bus_c.index = 3'(idx); bus_c.data_in = din; end
        endcase
        @(posedge clk);
        #1;
        case (sel)
            0: begin
                o_dout = 16'(bus_a.data_out); o_v = bus_a.out_valid; o_e = bus_a.error;
                o_full = bus_a.full; o_empty = bus_a.empty; o_count = int'(bus_a.count);
            end
            1: begin
                o_dout = 16'(bus_b.data_out); o_v = bus_b.out_valid; o_e = bus_b.error;
                o_full = bus_b.full; o_empty = bus_b.empty; o_count = int'(bus_b.count);
            end
            default: begin
                o_dout = bus_c.data_out; o_v = bus_c.out_valid; o_e = bus_c.error;
                o_full = bus_c.full; o_empty = bus_c.empty; o_count = int'(bus_c.count);
            end
        endcase
        model(cmd, idx, din, rst);
        chk({tag, ".data_out"},  32'(o_dout),  32'(m_dout));
        chk({tag, ".out_valid"}, 32'(o_v),     32'(m_v));
        chk({tag, ".error"},     32'(o_e),     32'(m_e));
        chk({tag, ".count"},     32'(o_count), 32'(q.size()));
        chk({tag, ".full"},      32'(o_full),  32'(q.size() == m_depth));
        chk({tag, ".empty"},     32'(o_empty), 32'(q.size() == 0));
    endtask

    initial begin
        reset_v = 3'b111;
        bus_a.command = CMD_NOP; bus_a.index = '0; bus_a.data_in = '0;
        bus_b.command = CMD_NOP; bus_b.index = '0; bus_b.data_in = '0;
        bus_c.command = CMD_NOP; bus_c.index = '0; bus_c.data_in = '0;
        repeat (2) @(posedge clk);

        // Bounded stack, depth 5
        use_dut(5, 0, 4);
        drive(0, CMD_NOP, 0, 0, 1'b1, "a_reset");
        for (int i = 1; i <= 3; i++) drive(0, CMD_PUSH, 0, 16'(i), 1'b0, "a_push");
        for (int i = 0; i < 3; i++)  drive(0, CMD_POP, 0, 0, 1'b0, "a_pop");
        drive(0, CMD_POP, 0, 0, 1'b0, "a_pop_empty");
        drive(0, CMD_NOP, 0, 0, 1'b0, "a_nop");
        drive(0, CMD_PUSH, 0, 16'hE, 1'b0, "a_push2");
        drive(0, CMD_PUSH, 0, 16'hD, 1'b0, "a_push2");
        drive(0, CMD_GET, 2, 0, 1'b0, "a_get_oob");
        drive(0, CMD_GET, 1, 0, 1'b0, "a_get1");
        drive(0, CMD_NOP, 0, 0, 1'b1, "a_reset2");
        for (int i = 1; i <= 6; i++) drive(0, CMD_PUSH, 0, 16'(i), 1'b0, "a_fill");
        drive(0, CMD_POP, 0, 0, 1'b0, "a_pop_full");
        drive(0, CMD_GET, 4, 0, 1'b0, "a_get4");
        drive(0, CMD_GET, 3, 0, 1'b0, "a_get3");
        drive(0, CMD_GET, 7, 0, 1'b0, "a_get7");
        drive(0, CMD_PUSH, 0, 16'h9, 1'b0, "a_p9");
        drive(0, CMD_PUSH, 0, 16'hA, 1'b0, "a_p10");
        drive(0, CMD_PUSH, 0, 0, 1'b1, "a_reset_push");
        drive(0, CMD_POP, 0, 0, 1'b0, "a_pop_after_reset");
        for (int i = 0; i < 80; i++)
            drive(0, cmd_e'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  16'($urandom), 1'b0, "a_rand");

        // Overwrite-oldest stack, depth 5
        use_dut(5, 1, 4);
        drive(1, CMD_NOP, 0, 0, 1'b1, "b_reset");
        for (int i = 1; i <= 7; i++) drive(1, CMD_PUSH, 0, 16'(i), 1'b0, "b_push");
        for (int i = 0; i <= 4; i++) drive(1, CMD_GET, i, 0, 1'b0, "b_get");
        drive(1, CMD_GET, 5, 0, 1'b0, "b_get5");
        for (int i = 0; i < 80; i++)
            drive(1, cmd_e'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  16'($urandom), 1'b0, "b_rand");

        // Wide power-of-two stack, depth 8
        use_dut(8, 0, 16);
        drive(2, CMD_NOP, 0, 0, 1'b1, "c_reset");
        for (int i = 0; i < 8; i++) drive(2, CMD_PUSH, 0, 16'hA5A5, 1'b0, "c_fill");
        drive(2, CMD_PUSH, 0, 16'h1234, 1'b0, "c_push_full");
        for (int i = 0; i < 20; i++)
            drive(2, (i % 2 == 0) ? CMD_POP : CMD_PUSH, 0, 16'($urandom), 1'b0, "c_alt");
        for (int i = 0; i < 8; i++) drive(2, CMD_GET, i, 0, 1'b0, "c_get");
        for (int i = 0; i < 80; i++)
            drive(2, cmd_e'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  16'($urandom), 1'b0, "c_rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
